// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: control-unit handshake plus the instruction-memory read port.
// master = fetch unit, slave = control unit / memory side.
interface fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
);
  logic               PC_en;
  logic               bra;
  logic [ADDR_W-1:0]  BADR;
  logic               hlt;
  logic               ir_ack;
  logic               mem_rdy;
  logic [INSTR_W-1:0] mem_data;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [ADDR_W-1:0]  PC;
  logic [INSTR_W-1:0] IR;
  logic               ir_valid;
  logic               halted;

  modport master (
    input  PC_en, bra, BADR, hlt, ir_ack, mem_rdy, mem_data,
    output mem_rd, mem_addr, PC, IR, ir_valid, halted
  );

  modport slave (
    output PC_en, bra, BADR, hlt, ir_ack, mem_rdy, mem_data,
    input  mem_rd, mem_addr, PC, IR, ir_valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC, reads instruction memory, presents IR with ir_valid/ir_ack; IR valid 1 cycle after mem_rdy.
// Backpressure: no new fetch is issued until the held IR is acked, flushed by a branch, or halted.
module fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               mem_rd_q, mem_rd_d;
  logic               halted_q, halted_d;
  logic               flush_q, flush_d;
  logic               halt_pend_q, halt_pend_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pend_addr_q <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      mem_rd_q    <= 1'b0;
      halted_q    <= 1'b0;
      flush_q     <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      mem_rd_q    <= mem_rd_d;
      halted_q    <= halted_d;
      flush_q     <= flush_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    mem_rd_d    = mem_rd_q;
    halted_d    = halted_q;
    flush_d     = flush_q;
    halt_pend_d = halt_pend_q;

    case (state_q)
      IDLE: begin
        if (bus.hlt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (bus.bra) begin
          pc_d = bus.BADR;
        end else if (bus.PC_en) begin
          state_d  = REQ;
          mem_rd_d = 1'b1;
        end
      end

      REQ: begin
        // The read stays outstanding until memory answers; halts and branches are deferred to that point.
        if (bus.hlt || halt_pend_q) begin
          if (bus.mem_rdy) begin
            state_d     = HALT;
            mem_rd_d    = 1'b0;
            halted_d    = 1'b1;
            halt_pend_d = 1'b0;
            flush_d     = 1'b0;
          end else begin
            halt_pend_d = 1'b1;
          end
        end else if (bus.bra) begin
          if (bus.mem_rdy) begin
            pc_d    = bus.BADR;
            flush_d = 1'b0;
          end else begin
            pend_addr_d = bus.BADR;
            flush_d     = 1'b1;
          end
        end else if (bus.mem_rdy) begin
          if (flush_q) begin
            pc_d    = pend_addr_q;
            flush_d = 1'b0;
          end else begin
            ir_d       = bus.mem_data;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
            mem_rd_d   = 1'b0;
            state_d    = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.hlt) begin
          ir_valid_d = 1'b0;
          halted_d   = 1'b1;
          state_d    = HALT;
        end else if (bus.bra) begin
          ir_valid_d = 1'b0;
          pc_d       = bus.BADR;
          state_d    = IDLE;
        end else if (bus.ir_ack) begin
          ir_valid_d = 1'b0;
          if (bus.PC_en) begin
            mem_rd_d = 1'b1;
            state_d  = REQ;
          end else begin
            state_d  = IDLE;
          end
        end
      end

      HALT: begin
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = pc_q;
  assign bus.PC       = pc_q;
  assign bus.IR       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory responder plus scoreboarded fetch scenarios.
module tb_fetch_unit;
  localparam int AW = 10;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(10'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int wait_cycles = 0;
  int mcnt = 0;
  int hs_cnt = 0;
  logic [IW-1:0] mem [0:1023];
  logic [IW-1:0] exp_ir_q [$];
  logic [AW-1:0] exp_pc_q [$];

  // Memory responder: mem_rdy after wait_cycles idle cycles of an outstanding read, one cycle wide.
  initial begin
    bus.mem_rdy  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      if (reset || !bus.mem_rd || bus.mem_rdy) begin
        bus.mem_rdy = 1'b0;
        mcnt = 0;
      end else if (mcnt >= wait_cycles) begin
        bus.mem_rdy  = 1'b1;
        bus.mem_data = mem[bus.mem_addr];
        hs_cnt++;
      end else begin
        mcnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (bus.ir_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if (bus.PC !== 10'd0 || bus.mem_addr !== 10'd0) begin
      bad++; $display("FAIL rst_pc: PC=%h mem_addr=%h want 000/000", bus.PC, bus.mem_addr);
    end
    total++;
    if (bus.IR !== 16'h0000 || bus.ir_valid !== 1'b0) begin
      bad++; $display("FAIL rst_ir: IR=%h ir_valid=%b want 0000/0", bus.IR, bus.ir_valid);
    end
    total++;
    if (bus.mem_rd !== 1'b0 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL rst_ctl: mem_rd=%b halted=%b want 0/0", bus.mem_rd, bus.halted);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_rd !== 1'b0 || bus.PC !== 10'd0) begin
      bad++; $display("FAIL rst_idle: mem_rd=%b PC=%h want 0/000", bus.mem_rd, bus.PC);
    end
  endtask

  task automatic test_zero_wait();
    int cyc;
    int hs0;
    logic [IW-1:0] e_ir;
    logic [AW-1:0] e_pc;
    wait_cycles = 0;
    hs0 = hs_cnt;
    bus.PC_en = 1'b1;
    @(negedge clk);
    bus.PC_en = 1'b0;
    exp_ir_q.push_back(16'h1234);
    exp_pc_q.push_back(10'd1);
    total++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'd0) begin
      bad++; $display("FAIL zw_req: mem_rd=%b mem_addr=%h want 1/000", bus.mem_rd, bus.mem_addr);
    end
    wait_valid(8, cyc);
    total++;
    if (bus.ir_valid !== 1'b1 || cyc !== 1) begin
      bad++; $display("FAIL zw_latency: ir_valid=%b cycles=%0d want 1/1", bus.ir_valid, cyc);
    end
    e_ir = exp_ir_q.pop_front();
    e_pc = exp_pc_q.pop_front();
    total++;
    if (bus.IR !== e_ir) begin
      bad++; $display("FAIL zw_ir: IR=%h want %h", bus.IR, e_ir);
    end
    total++;
    if (bus.PC !== e_pc) begin
      bad++; $display("FAIL zw_pc: PC=%h want %h", bus.PC, e_pc);
    end
    bus.ir_ack = 1'b1;
    @(negedge clk);
    bus.ir_ack = 1'b0;
    total++;
    if (bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL zw_ack: ir_valid=%b mem_rd=%b want 0/0", bus.ir_valid, bus.mem_rd);
    end
    total++;
    if (hs_cnt - hs0 !== 1) begin
      bad++; $display("FAIL zw_fetches: got %0d want 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    int hs0;
    logic [IW-1:0] e_ir;
    logic [AW-1:0] e_pc;
    wait_cycles = 3;
    hs0 = hs_cnt;
    bus.PC_en = 1'b1;
    @(negedge clk);
    bus.PC_en = 1'b0;
    exp_ir_q.push_back(mem[1]);
    exp_pc_q.push_back(10'd2);
    total++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'd1) begin
      bad++; $display("FAIL ws_req: mem_rd=%b mem_addr=%h want 1/001", bus.mem_rd, bus.mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'd1 || bus.ir_valid !== 1'b0) begin
        bad++; $display("FAIL ws_hold%0d: mem_rd=%b mem_addr=%h ir_valid=%b want 1/001/0",
                        i, bus.mem_rd, bus.mem_addr, bus.ir_valid);
      end
    end
    wait_valid(10, cyc);
    e_ir = exp_ir_q.pop_front();
    e_pc = exp_pc_q.pop_front();
    total++;
    if (bus.ir_valid !== 1'b1 || cyc !== 1) begin
      bad++; $display("FAIL ws_latency: ir_valid=%b cycles=%0d want 1/1", bus.ir_valid, cyc);
    end
    total++;
    if (bus.IR !== e_ir || bus.PC !== e_pc) begin
      bad++; $display("FAIL ws_result: IR=%h PC=%h want %h/%h", bus.IR, bus.PC, e_ir, e_pc);
    end
    // Back-to-back: ack with PC_en issues the next read immediately.
    bus.ir_ack = 1'b1;
    bus.PC_en  = 1'b1;
    exp_ir_q.push_back(mem[2]);
    exp_pc_q.push_back(10'd3);
    @(negedge clk);
    bus.ir_ack = 1'b0;
    bus.PC_en  = 1'b0;
    total++;
    if (bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'd2) begin
      bad++; $display("FAIL b2b_req: ir_valid=%b mem_rd=%b mem_addr=%h want 0/1/002",
                      bus.ir_valid, bus.mem_rd, bus.mem_addr);
    end
    wait_valid(12, cyc);
    e_ir = exp_ir_q.pop_front();
    e_pc = exp_pc_q.pop_front();
    total++;
    if (bus.ir_valid !== 1'b1 || bus.IR !== e_ir || bus.PC !== e_pc) begin
      bad++; $display("FAIL b2b_result: ir_valid=%b IR=%h PC=%h want 1/%h/%h",
                      bus.ir_valid, bus.IR, bus.PC, e_ir, e_pc);
    end
    bus.ir_ack = 1'b1;
    @(negedge clk);
    bus.ir_ack = 1'b0;
    total++;
    if (hs_cnt - hs0 !== 2) begin
      bad++; $display("FAIL ws_fetches: got %0d want 2", hs_cnt - hs0);
    end
  endtask

  task automatic test_branch_flush();
    int cyc;
    logic [IW-1:0] e_ir;
    logic [AW-1:0] e_pc;
    bus.bra  = 1'b1;
    bus.BADR = 10'd5;
    @(negedge clk);
    bus.bra = 1'b0;
    total++;
    if (bus.PC !== 10'd5 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL br_idle: PC=%h mem_rd=%b want 005/0", bus.PC, bus.mem_rd);
    end
    wait_cycles = 2;
    bus.PC_en = 1'b1;
    @(negedge clk);
    bus.PC_en = 1'b0;
    bus.bra   = 1'b1;
    bus.BADR  = 10'h2A;
    exp_ir_q.push_back(mem[10'h2A]);
    exp_pc_q.push_back(10'h2B);
    @(negedge clk);
    bus.bra = 1'b0;
    total++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'd5 || bus.ir_valid !== 1'b0) begin
      bad++; $display("FAIL br_hold: mem_rd=%b mem_addr=%h ir_valid=%b want 1/005/0",
                      bus.mem_rd, bus.mem_addr, bus.ir_valid);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'h2A || bus.ir_valid !== 1'b0) begin
      bad++; $display("FAIL br_redirect: mem_rd=%b mem_addr=%h ir_valid=%b want 1/02a/0",
                      bus.mem_rd, bus.mem_addr, bus.ir_valid);
    end
    wait_valid(10, cyc);
    e_ir = exp_ir_q.pop_front();
    e_pc = exp_pc_q.pop_front();
    total++;
    if (bus.ir_valid !== 1'b1 || bus.IR !== e_ir || bus.PC !== e_pc) begin
      bad++; $display("FAIL br_result: ir_valid=%b IR=%h PC=%h want 1/%h/%h",
                      bus.ir_valid, bus.IR, bus.PC, e_ir, e_pc);
    end
    bus.ir_ack = 1'b1;
    @(negedge clk);
    bus.ir_ack = 1'b0;
    // Branch landing on the same cycle as mem_rdy.
    wait_cycles = 0;
    bus.PC_en = 1'b1;
    @(negedge clk);
    bus.PC_en = 1'b0;
    bus.bra   = 1'b1;
    bus.BADR  = 10'h100;
    exp_ir_q.push_back(mem[10'h100]);
    exp_pc_q.push_back(10'h101);
    @(negedge clk);
    bus.bra = 1'b0;
    total++;
    if (bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'h100) begin
      bad++; $display("FAIL br_coinc: ir_valid=%b mem_rd=%b mem_addr=%h want 0/1/100",
                      bus.ir_valid, bus.mem_rd, bus.mem_addr);
    end
    wait_valid(8, cyc);
    e_ir = exp_ir_q.pop_front();
    e_pc = exp_pc_q.pop_front();
    total++;
    if (bus.ir_valid !== 1'b1 || bus.IR !== e_ir || bus.PC !== e_pc) begin
      bad++; $display("FAIL br_coinc_result: ir_valid=%b IR=%h PC=%h want 1/%h/%h",
                      bus.ir_valid, bus.IR, bus.PC, e_ir, e_pc);
    end
    bus.ir_ack = 1'b1;
    @(negedge clk);
    bus.ir_ack = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    logic [IW-1:0] e_ir;
    logic [AW-1:0] e_pc;
    bus.bra  = 1'b1;
    bus.BADR = 10'h3FF;
    @(negedge clk);
    bus.bra = 1'b0;
    wait_cycles = 0;
    bus.PC_en = 1'b1;
    @(negedge clk);
    bus.PC_en = 1'b0;
    exp_ir_q.push_back(mem[10'h3FF]);
    exp_pc_q.push_back(10'h000);
    wait_valid(8, cyc);
    e_ir = exp_ir_q.pop_front();
    e_pc = exp_pc_q.pop_front();
    total++;
    if (bus.ir_valid !== 1'b1 || bus.IR !== e_ir || bus.PC !== e_pc) begin
      bad++; $display("FAIL wrap_result: ir_valid=%b IR=%h PC=%h want 1/%h/%h",
                      bus.ir_valid, bus.IR, bus.PC, e_ir, e_pc);
    end
    bus.bra    = 1'b1;
    bus.BADR   = 10'd7;
    bus.ir_ack = 1'b1;
    @(negedge clk);
    bus.bra    = 1'b0;
    bus.ir_ack = 1'b0;
    total++;
    if (bus.ir_valid !== 1'b0 || bus.PC !== 10'd7 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL wrap_bra_ack: ir_valid=%b PC=%h mem_rd=%b want 0/007/0",
                      bus.ir_valid, bus.PC, bus.mem_rd);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.ir_valid !== 1'b0 || bus.PC !== 10'd7 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL wrap_idle: ir_valid=%b PC=%h mem_rd=%b want 0/007/0",
                      bus.ir_valid, bus.PC, bus.mem_rd);
    end
  endtask

  task automatic test_halt();
    int cyc;
    logic [IW-1:0] e_ir;
    logic [AW-1:0] e_pc;
    wait_cycles = 0;
    bus.PC_en = 1'b1;
    @(negedge clk);
    bus.PC_en = 1'b0;
    exp_ir_q.push_back(mem[7]);
    exp_pc_q.push_back(10'd8);
    total++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'd7) begin
      bad++; $display("FAIL halt_fetch: mem_rd=%b mem_addr=%h want 1/007", bus.mem_rd, bus.mem_addr);
    end
    wait_valid(8, cyc);
    e_ir = exp_ir_q.pop_front();
    e_pc = exp_pc_q.pop_front();
    total++;
    if (bus.ir_valid !== 1'b1 || bus.IR !== e_ir || bus.PC !== e_pc) begin
      bad++; $display("FAIL halt_result: ir_valid=%b IR=%h PC=%h want 1/%h/%h",
                      bus.ir_valid, bus.IR, bus.PC, e_ir, e_pc);
    end
    bus.hlt = 1'b1;
    @(negedge clk);
    bus.hlt = 1'b0;
    total++;
    if (bus.halted !== 1'b1 || bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL halt_enter: halted=%b ir_valid=%b mem_rd=%b want 1/0/0",
                      bus.halted, bus.ir_valid, bus.mem_rd);
    end
    bus.PC_en = 1'b1;
    bus.bra   = 1'b1;
    bus.BADR  = 10'h55;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_rd !== 1'b0 || bus.PC !== 10'd8 || bus.halted !== 1'b1 || bus.ir_valid !== 1'b0) begin
        bad++; $display("FAIL halt_stay%0d: mem_rd=%b PC=%h halted=%b ir_valid=%b want 0/008/1/0",
                        i, bus.mem_rd, bus.PC, bus.halted, bus.ir_valid);
      end
    end
    bus.PC_en = 1'b0;
    bus.bra   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.halted !== 1'b0 || bus.PC !== 10'd0 || bus.mem_rd !== 1'b0) begin
      bad++; $display("FAIL halt_reset: halted=%b PC=%h mem_rd=%b want 0/000/0",
                      bus.halted, bus.PC, bus.mem_rd);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    wait_cycles = 5;
    bus.bra  = 1'b1;
    bus.BADR = 10'd3;
    @(negedge clk);
    bus.bra = 1'b0;
    bus.PC_en = 1'b1;
    @(negedge clk);
    bus.PC_en = 1'b0;
    total++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'd3) begin
      bad++; $display("FAIL mid_req: mem_rd=%b mem_addr=%h want 1/003", bus.mem_rd, bus.mem_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.mem_rd !== 1'b0 || bus.PC !== 10'd0 || bus.mem_addr !== 10'd0) begin
      bad++; $display("FAIL mid_reset: mem_rd=%b PC=%h mem_addr=%h want 0/000/000",
                      bus.mem_rd, bus.PC, bus.mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_rd !== 1'b0 || bus.PC !== 10'd0 || bus.ir_valid !== 1'b0) begin
      bad++; $display("FAIL mid_after: mem_rd=%b PC=%h ir_valid=%b want 0/000/0",
                      bus.mem_rd, bus.PC, bus.ir_valid);
    end
  endtask

  task automatic test_halt_pending();
    int cyc;
    wait_cycles = 2;
    bus.PC_en = 1'b1;
    @(negedge clk);
    bus.PC_en = 1'b0;
    bus.hlt   = 1'b1;
    @(negedge clk);
    bus.hlt = 1'b0;
    total++;
    if (bus.mem_rd !== 1'b1 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL hp_wait: mem_rd=%b halted=%b want 1/0", bus.mem_rd, bus.halted);
    end
    cyc = 0;
    while (bus.halted !== 1'b1 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (bus.halted !== 1'b1 || bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b0 || bus.PC !== 10'd0) begin
      bad++; $display("FAIL hp_halt: halted=%b ir_valid=%b mem_rd=%b PC=%h want 1/0/0/000",
                      bus.halted, bus.ir_valid, bus.mem_rd, bus.PC);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 ^ 16'(i);
    mem[0] = 16'h1234;
    reset       = 1'b1;
    bus.PC_en   = 1'b0;
    bus.bra     = 1'b0;
    bus.BADR    = '0;
    bus.hlt     = 1'b0;
    bus.ir_ack  = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch_flush();
    test_wrap();
    test_halt();
    test_reset_mid_req();
    test_halt_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
